// File: rtl/sh7604_line_fill_pkg.sv
// Shared types and constants for the SH7604 cache line-fill sequencer.
// Word ordering is a plain 2-bit add so the sequence wraps inside the 16-byte line.
package sh7604_line_fill_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitd,
      StDone
   } line_fill_state_e;

   localparam int unsigned LineBytes = 16;

   // Word index of beat `beat` when the fill starts at word `crit`.
   function automatic logic [1:0] word_idx(input logic [1:0] crit, input logic [1:0] beat);
      return crit + beat;
   endfunction

endpackage

// File: rtl/sh7604_line_fill.sv
// Cache line-fill sequencer: four critical-word-first IBUS reads per line, held as one
// locked burst, each returned longword streamed to the cache data array.
module sh7604_line_fill
   import sh7604_line_fill_pkg::*;
#(
   parameter int unsigned LineWords = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ce_r_i,
   input  logic        fill_req_i,
   input  logic [31:0] fill_a_i,
   output logic        fill_busy_o,
   output logic        fill_we_o,
   output logic [1:0]  fill_wa_o,
   output logic [31:0] fill_wd_o,
   output logic        crit_vld_o,
   output logic        fill_done_o,
   output logic [31:0] ibus_a_o,
   output logic [3:0]  ibus_ba_o,
   output logic        ibus_we_o,
   output logic        ibus_req_o,
   output logic        ibus_burst_o,
   output logic        ibus_lock_o,
   input  logic [31:0] ibus_di_i,
   input  logic        ibus_busy_i
);

   localparam int unsigned OffsW    = $clog2(LineBytes);
   localparam logic [1:0]  LastBeat = 2'(LineWords - 1);

   line_fill_state_e   state_q, state_d;
   logic [31-OffsW:0]  line_q, line_d;
   logic [1:0]         crit_q, crit_d;
   logic [1:0]         beat_q, beat_d;
   logic [1:0]         word_q, word_d;
   logic               req_q, req_d;
   logic               busy_q, busy_d;
   logic               we_q, we_d;
   logic [1:0]         wa_q, wa_d;
   logic [31:0]        wd_q, wd_d;
   logic               crit_vld_q, crit_vld_d;
   logic               done_q, done_d;

   // Byte offset bits of the miss address carry no information for a longword fill.
   logic unused_addr_bits;
   assign unused_addr_bits = ^fill_a_i[1:0];

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      crit_d     = crit_q;
      beat_d     = beat_q;
      word_d     = word_q;
      req_d      = req_q;
      busy_d     = busy_q;
      wa_d       = wa_q;
      wd_d       = wd_q;
      we_d       = 1'b0;
      crit_vld_d = 1'b0;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (fill_req_i) begin
               line_d  = fill_a_i[31:OffsW];
               crit_d  = fill_a_i[OffsW-1:2];
               word_d  = fill_a_i[OffsW-1:2];
               beat_d  = 2'd0;
               req_d   = 1'b1;
               busy_d  = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (ibus_busy_i) begin
               state_d = StWaitd;
            end
         end
         StWaitd: begin
            if (!ibus_busy_i) begin
               wd_d       = ibus_di_i;
               wa_d       = word_idx(crit_q, beat_q);
               we_d       = 1'b1;
               crit_vld_d = (beat_q == 2'd0);
               if (beat_q == LastBeat) begin
                  req_d   = 1'b0;
                  state_d = StDone;
               end else begin
                  beat_d  = beat_q + 2'd1;
                  word_d  = word_idx(crit_q, beat_q + 2'd1);
                  state_d = StIssue;
               end
            end
         end
         StDone: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         line_q     <= '0;
         crit_q     <= 2'd0;
         beat_q     <= 2'd0;
         word_q     <= 2'd0;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
         we_q       <= 1'b0;
         wa_q       <= 2'd0;
         wd_q       <= 32'd0;
         crit_vld_q <= 1'b0;
         done_q     <= 1'b0;
      end else if (ce_r_i) begin
         state_q    <= state_d;
         line_q     <= line_d;
         crit_q     <= crit_d;
         beat_q     <= beat_d;
         word_q     <= word_d;
         req_q      <= req_d;
         busy_q     <= busy_d;
         we_q       <= we_d;
         wa_q       <= wa_d;
         wd_q       <= wd_d;
         crit_vld_q <= crit_vld_d;
         done_q     <= done_d;
      end
   end

   // Burst and lock share the request register so the BSC never sees the line split.
   assign ibus_req_o   = req_q;
   assign ibus_burst_o = req_q;
   assign ibus_lock_o  = req_q;
   assign ibus_ba_o    = req_q ? 4'b1111 : 4'b0000;
   assign ibus_we_o    = 1'b0;
   assign ibus_a_o     = {line_q, word_q, 2'b00};

   assign fill_busy_o  = busy_q;
   assign fill_we_o    = we_q;
   assign fill_wa_o    = wa_q;
   assign fill_wd_o    = wd_q;
   assign crit_vld_o   = crit_vld_q;
   assign fill_done_o  = done_q;

endmodule
